// File: rtl/eth_frame_gen.sv
// Ethernet test-frame generator driving an 8-bit AXI-Stream MAC TX port.
// Define ETH_FRAME_GEN_SEQ_EN to carry the frame counter in payload bytes 14-17.
module eth_frame_gen #(
  parameter int C_GAP_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [10:0]            frame_len,
  input  logic [C_GAP_WIDTH-1:0] gap_len,
  input  logic [47:0]            dst_mac,
  input  logic [47:0]            src_mac,
  input  logic [15:0]            ethertype,
  input  logic                   clear,
  input  logic                   tx_error,
  output logic [7:0]             tx_axis_tdata,
  output logic                   tx_axis_tvalid,
  output logic                   tx_axis_tlast,
  output logic                   tx_axis_tuser,
  input  logic                   tx_axis_tready,
  output logic [31:0]            frame_count,
  output logic [15:0]            error_count,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, FRAME, GAP} state_t;

  state_t                 state;
  logic [10:0]            idx;
  logic [10:0]            len_q;
  logic [C_GAP_WIDTH-1:0] gap_q;
  logic [C_GAP_WIDTH-1:0] gap_cnt;
  logic [47:0]            dst_q;
  logic [47:0]            src_q;
  logic [15:0]            type_q;
`ifdef ETH_FRAME_GEN_SEQ_EN
  logic [31:0]            seq_q;
  logic [31:0]            cur_seq;
`endif

  logic        hs;
  logic        last_hs;
  logic        gap_done;
  logic        start;
  logic [31:0] fc_next;
  logic [10:0] next_idx;
  logic [10:0] next_len;
  logic [47:0] cur_dst;
  logic [47:0] cur_src;
  logic [15:0] cur_type;
  logic [7:0]  next_byte;
  logic        next_last;

  function automatic logic [7:0] hdr_byte(input logic [3:0] i, input logic [47:0] d,
                                          input logic [47:0] s, input logic [15:0] t);
    logic [7:0] b;
    case (i)
      4'd0:    b = d[47:40];
      4'd1:    b = d[39:32];
      4'd2:    b = d[31:24];
      4'd3:    b = d[23:16];
      4'd4:    b = d[15:8];
      4'd5:    b = d[7:0];
      4'd6:    b = s[47:40];
      4'd7:    b = s[39:32];
      4'd8:    b = s[31:24];
      4'd9:    b = s[23:16];
      4'd10:   b = s[15:8];
      4'd11:   b = s[7:0];
      4'd12:   b = t[15:8];
      4'd13:   b = t[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign tx_axis_tuser = 1'b0;

  // Next-byte pipeline: either byte 0 of a fresh frame (from live inputs) or the
  // next byte of the current frame (from latched fields), so tdata stays registered.
  always_comb begin
    hs       = tx_axis_tvalid && tx_axis_tready;
    last_hs  = hs && tx_axis_tlast;
    gap_done = (state == GAP) && (gap_cnt == C_GAP_WIDTH'(1));
    start    = enable && ((state == IDLE) || (last_hs && (gap_q == '0)) || gap_done);

    fc_next = frame_count;
    if (clear)
      fc_next = 32'd0;
    else if (last_hs)
      fc_next = frame_count + 32'd1;

    cur_dst  = start ? dst_mac : dst_q;
    cur_src  = start ? src_mac : src_q;
    cur_type = start ? ethertype : type_q;
    next_idx = start ? 11'd0 : idx + 11'd1;
    next_len = start ? ((frame_len < 11'd18) ? 11'd18 : frame_len) : len_q;

    if (next_idx < 11'd14)
      next_byte = hdr_byte(next_idx[3:0], cur_dst, cur_src, cur_type);
    else
      next_byte = 8'(next_idx - 11'd14);

`ifdef ETH_FRAME_GEN_SEQ_EN
    cur_seq = start ? fc_next : seq_q;
    case (next_idx)
      11'd14:  next_byte = cur_seq[31:24];
      11'd15:  next_byte = cur_seq[23:16];
      11'd16:  next_byte = cur_seq[15:8];
      11'd17:  next_byte = cur_seq[7:0];
      default: ;
    endcase
`endif

    next_last = (next_idx == (next_len - 11'd1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      tx_axis_tvalid <= 1'b0;
      tx_axis_tlast  <= 1'b0;
      tx_axis_tdata  <= 8'h00;
      busy           <= 1'b0;
      frame_count    <= 32'd0;
      error_count    <= 16'd0;
      idx            <= 11'd0;
      len_q          <= 11'd18;
      gap_q          <= '0;
      gap_cnt        <= '0;
      dst_q          <= 48'd0;
      src_q          <= 48'd0;
      type_q         <= 16'd0;
`ifdef ETH_FRAME_GEN_SEQ_EN
      seq_q          <= 32'd0;
`endif
    end else begin
      frame_count <= fc_next;
      if (clear)
        error_count <= 16'd0;
      else if (tx_error && (error_count != 16'hFFFF))
        error_count <= error_count + 16'd1;

      if (start) begin
        state          <= FRAME;
        busy           <= 1'b1;
        tx_axis_tvalid <= 1'b1;
        idx            <= next_idx;
        tx_axis_tdata  <= next_byte;
        tx_axis_tlast  <= next_last;
        len_q          <= next_len;
        gap_q          <= gap_len;
        dst_q          <= dst_mac;
        src_q          <= src_mac;
        type_q         <= ethertype;
`ifdef ETH_FRAME_GEN_SEQ_EN
        seq_q          <= fc_next;
`endif
      end else begin
        case (state)
          FRAME: begin
            if (hs) begin
              if (tx_axis_tlast) begin
                tx_axis_tvalid <= 1'b0;
                tx_axis_tlast  <= 1'b0;
                if (gap_q != '0) begin
                  state   <= GAP;
                  gap_cnt <= gap_q;
                end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
                end
              end else begin
                idx           <= next_idx;
                tx_axis_tdata <= next_byte;
                tx_axis_tlast <= next_last;
              end
            end
          end
          GAP: begin
            if (gap_done) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              gap_cnt <= gap_cnt - C_GAP_WIDTH'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
